// File: rtl/mnist_frame_feeder.sv
// Buffers one MNIST frame from the host byte stream, replays it to the inference core
// at a paced rate, then latches and strobes the core's classification result.
module mnist_frame_feeder #(
   parameter int unsigned NUM_PIXELS = 784,
   parameter int unsigned PIXEL_GAP  = 0,
   parameter int unsigned TIMEOUT    = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        frame_sync,
   output logic        pix_valid,
   output logic [7:0]  pix_data,
   input  logic [31:0] core_result,
   input  logic        core_result_valid,
   output logic [31:0] frame_result,
   output logic        frame_result_valid,
   output logic        busy,
   output logic        drop_err,
   output logic        timeout_err
);

   localparam int unsigned PTR_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam int unsigned GAP_W = (PIXEL_GAP > 0) ? $clog2(PIXEL_GAP + 1) : 1;
   localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [PTR_W-1:0] LAST_ADDR  = PTR_W'(NUM_PIXELS - 1);
   localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(PIXEL_GAP);
   localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);

   localparam logic [1:0] ST_LOAD   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;

   logic [7:0]       mem [NUM_PIXELS];

   logic [1:0]       state_q, state_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             last_q, last_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             pix_valid_q, pix_valid_d;
   logic [7:0]       pix_data_q, pix_data_d;
   logic [31:0]      frame_result_q, frame_result_d;
   logic             frame_result_valid_q, frame_result_valid_d;
   logic             busy_q, busy_d;
   logic             drop_err_q, drop_err_d;
   logic             timeout_err_q, timeout_err_d;

   logic             mem_we;
   logic [PTR_W-1:0] mem_waddr;
   logic             rd_en;
   logic             drop_set;
   logic             tmo_set;

   // Frame buffer write port; no reset so it maps onto a plain RAM
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= in_data;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d              = state_q;
      wptr_d               = wptr_q;
      rptr_d               = rptr_q;
      gap_d                = gap_q;
      last_d               = last_q;
      tmo_d                = tmo_q;
      pix_valid_d          = 1'b0;
      pix_data_d           = pix_data_q;
      frame_result_d       = frame_result_q;
      frame_result_valid_d = 1'b0;
      mem_we               = 1'b0;
      mem_waddr            = frame_sync ? '0 : wptr_q;
      rd_en                = 1'b0;
      drop_set             = 1'b0;
      tmo_set              = 1'b0;

      case (state_q)
         ST_LOAD: begin
            if (frame_sync) begin
               wptr_d = '0;
            end
            if (in_valid) begin
               mem_we = 1'b1;
               if (mem_waddr == LAST_ADDR) begin
                  wptr_d  = '0;
                  rptr_d  = '0;
                  gap_d   = '0;
                  last_d  = 1'b0;
                  state_d = ST_STREAM;
               end else begin
                  wptr_d = mem_waddr + PTR_W'(1);
               end
            end
         end

         ST_STREAM: begin
            drop_set = in_valid;
            // last_q marks the cycle the final pixel is on the wire
            if (last_q) begin
               last_d  = 1'b0;
               tmo_d   = '0;
               state_d = ST_WAIT;
            end else if (gap_q == '0) begin
               rd_en       = 1'b1;
               pix_valid_d = 1'b1;
               gap_d       = GAP_RELOAD;
               if (rptr_q == LAST_ADDR) begin
                  rptr_d = '0;
                  last_d = 1'b1;
               end else begin
                  rptr_d = rptr_q + PTR_W'(1);
               end
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end

         ST_WAIT: begin
            drop_set = in_valid;
            // A result on the expiry cycle still wins over the timeout
            if (core_result_valid) begin
               frame_result_d       = core_result;
               frame_result_valid_d = 1'b1;
               state_d              = ST_LOAD;
            end else if (tmo_q == TMO_LAST) begin
               tmo_set = 1'b1;
               state_d = ST_LOAD;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         default: begin
            state_d = ST_LOAD;
         end
      endcase

      if (rd_en) begin
         pix_data_d = mem[rptr_q];
      end

      drop_err_d    = drop_set | (drop_err_q & ~frame_sync);
      timeout_err_d = tmo_set | (timeout_err_q & ~frame_sync);
      busy_d        = (state_d != ST_LOAD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q              <= ST_LOAD;
         wptr_q               <= '0;
         rptr_q               <= '0;
         gap_q                <= '0;
         last_q               <= 1'b0;
         tmo_q                <= '0;
         pix_valid_q          <= 1'b0;
         pix_data_q           <= '0;
         frame_result_q       <= '0;
         frame_result_valid_q <= 1'b0;
         busy_q               <= 1'b0;
         drop_err_q           <= 1'b0;
         timeout_err_q        <= 1'b0;
      end else begin
         state_q              <= state_d;
         wptr_q               <= wptr_d;
         rptr_q               <= rptr_d;
         gap_q                <= gap_d;
         last_q               <= last_d;
         tmo_q                <= tmo_d;
         pix_valid_q          <= pix_valid_d;
         pix_data_q           <= pix_data_d;
         frame_result_q       <= frame_result_d;
         frame_result_valid_q <= frame_result_valid_d;
         busy_q               <= busy_d;
         drop_err_q           <= drop_err_d;
         timeout_err_q        <= timeout_err_d;
      end
   end

   assign pix_valid          = pix_valid_q;
   assign pix_data           = pix_data_q;
   assign frame_result       = frame_result_q;
   assign frame_result_valid = frame_result_valid_q;
   assign busy               = busy_q;
   assign drop_err           = drop_err_q;
   assign timeout_err        = timeout_err_q;

endmodule

// File: tb/tb_mnist_frame_feeder.sv
// Directed bench for mnist_frame_feeder: one instance with no pixel gap, one with a
// gap of 2, both with a 16-cycle result timeout.
module tb_mnist_frame_feeder;

   localparam int N = 784;

   logic        clk = 1'b0;
   logic        rst;
   logic        iv   [2];
   logic [7:0]  id   [2];
   logic        fs   [2];
   logic [31:0] cr   [2];
   logic        crv  [2];
   logic        pv   [2];
   logic [7:0]  pd   [2];
   logic [31:0] fr   [2];
   logic        frv  [2];
   logic        bsy  [2];
   logic        derr [2];
   logic        terr [2];

   always #5 clk = ~clk;

   mnist_frame_feeder #(.NUM_PIXELS(N), .PIXEL_GAP(0), .TIMEOUT(16)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id[0]), .frame_sync(fs[0]),
      .pix_valid(pv[0]), .pix_data(pd[0]), .core_result(cr[0]), .core_result_valid(crv[0]),
      .frame_result(fr[0]), .frame_result_valid(frv[0]), .busy(bsy[0]),
      .drop_err(derr[0]), .timeout_err(terr[0]));

   mnist_frame_feeder #(.NUM_PIXELS(N), .PIXEL_GAP(2), .TIMEOUT(16)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id[1]), .frame_sync(fs[1]),
      .pix_valid(pv[1]), .pix_data(pd[1]), .core_result(cr[1]), .core_result_valid(crv[1]),
      .frame_result(fr[1]), .frame_result_valid(frv[1]), .busy(bsy[1]),
      .drop_err(derr[1]), .timeout_err(terr[1]));

   typedef struct {
      int          d;
      int          mode;     // 0: ramp i mod 256, 1: constant val
      logic [7:0]  val;
      bit          sync;     // frame_sync pulse before the frame
      int          delay;    // result delay after WAIT entry, -1 = no result
      logic [31:0] res;
      bit          drop;     // inject 5 bytes during STREAM
      logic        exp_tmo;
      logic        exp_drop;
      logic [31:0] exp_fr;
   } vec_t;

   vec_t        vecs [7];
   int          cyc   = 0;
   int          total = 0;
   int          bad   = 0;
   logic [7:0]  cap_data [2][N];
   int          cap_cyc  [2][N];
   int          cap_n    [2];

   task automatic tick();
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (pv[d]) begin
            if (cap_n[d] < N) begin
               cap_data[d][cap_n[d]] = pd[d];
               cap_cyc[d][cap_n[d]]  = cyc;
            end
            cap_n[d]++;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int mode, input logic [7:0] val, input int i);
      return (mode == 0) ? 8'(i) : val;
   endfunction

   task automatic send_frame(input int d, input int mode, input logic [7:0] val,
                             input bit sync_first, output int t_last);
      t_last = 0;
      for (int i = 0; i < N; i++) begin
         iv[d]  = 1'b1;
         id[d]  = exp_byte(mode, val, i);
         fs[d]  = sync_first && (i == 0);
         t_last = cyc;
         tick();
      end
      iv[d] = 1'b0;
      fs[d] = 1'b0;
   endtask

   task automatic capture(input int d, input int gap, input int mode, input logic [7:0] val,
                          input bit drop, input int t_last, output int s_last);
      int guard;
      int inj;
      int errs;
      guard = 0;
      inj   = 0;
      while (cap_n[d] < N && guard < N * (gap + 1) + 50) begin
         if (drop && inj < 5 && cap_n[d] >= 10) begin
            iv[d] = 1'b1;
            id[d] = 8'hFF;
            fs[d] = (inj == 4);
            inj++;
         end else begin
            iv[d] = 1'b0;
            fs[d] = 1'b0;
         end
         tick();
         guard++;
      end
      iv[d] = 1'b0;
      fs[d] = 1'b0;
      check("stream_count", 32'(cap_n[d]), 32'(N));
      errs = 0;
      for (int k = 0; k < N && k < cap_n[d]; k++) begin
         if (cap_cyc[d][k] != t_last + 2 + k * (gap + 1)) errs++;
         if (cap_data[d][k] !== exp_byte(mode, val, k)) errs++;
      end
      check("stream_timing_data_errors", 32'(errs), 32'd0);
      check("first_pixel_offset", (cap_n[d] > 0) ? 32'(cap_cyc[d][0] - t_last) : 32'hFFFF_FFFF, 32'd2);
      s_last = (cap_n[d] >= N) ? cap_cyc[d][N-1] : cyc;
   endtask

   task automatic resolve(input int d, input int s_last, input int delay, input logic [31:0] result,
                          input logic exp_tmo, input logic exp_drop, input logic [31:0] exp_fr);
      int w;
      w = s_last + 1;
      tick();
      check("busy_in_wait", 32'(bsy[d]), 32'd1);
      check("no_extra_pixel", 32'(pv[d]), 32'd0);
      if (delay >= 0) begin
         while (cyc < w + delay) tick();
         crv[d] = 1'b1;
         cr[d]  = result;
         tick();
         crv[d] = 1'b0;
         cr[d]  = 32'h0;
         check("result_strobe", 32'(frv[d]), 32'd1);
         check("frame_result", fr[d], exp_fr);
         check("busy_after_result", 32'(bsy[d]), 32'd0);
      end else begin
         while (cyc < w + 15) tick();
         check("timeout_not_early", 32'(terr[d]), 32'd0);
         check("busy_before_timeout", 32'(bsy[d]), 32'd1);
         tick();
         check("timeout_err_rise", 32'(terr[d]), 32'd1);
         check("busy_after_timeout", 32'(bsy[d]), 32'd0);
         check("no_strobe_on_timeout", 32'(frv[d]), 32'd0);
         check("frame_result_kept", fr[d], exp_fr);
      end
      check("timeout_err_state", 32'(terr[d]), 32'(exp_tmo));
      check("drop_err_state", 32'(derr[d]), 32'(exp_drop));
   endtask

   initial begin
      int t_last;
      int s_last;
      int n_before;
      int guard;

      vecs[0] = '{d:0, mode:0, val:8'h00, sync:0, delay:3,  res:32'd7,         drop:0, exp_tmo:0, exp_drop:0, exp_fr:32'd7};
      vecs[1] = '{d:1, mode:0, val:8'h00, sync:0, delay:0,  res:32'h1234_5678, drop:0, exp_tmo:0, exp_drop:0, exp_fr:32'h1234_5678};
      vecs[2] = '{d:0, mode:1, val:8'h3C, sync:0, delay:-1, res:32'h0,         drop:0, exp_tmo:1, exp_drop:0, exp_fr:32'd7};
      vecs[3] = '{d:0, mode:1, val:8'hC3, sync:1, delay:15, res:32'hDEAD_BEEF, drop:0, exp_tmo:0, exp_drop:0, exp_fr:32'hDEAD_BEEF};
      vecs[4] = '{d:0, mode:0, val:8'h00, sync:0, delay:2,  res:32'h0000_00A5, drop:1, exp_tmo:0, exp_drop:1, exp_fr:32'h0000_00A5};
      vecs[5] = '{d:1, mode:1, val:8'h55, sync:1, delay:5,  res:32'd9,         drop:1, exp_tmo:0, exp_drop:1, exp_fr:32'd9};
      vecs[6] = '{d:0, mode:1, val:8'h01, sync:1, delay:1,  res:32'd3,         drop:0, exp_tmo:0, exp_drop:0, exp_fr:32'd3};

      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         iv[d] = 1'b0; id[d] = 8'h0; fs[d] = 1'b0; cr[d] = 32'h0; crv[d] = 1'b0; cap_n[d] = 0;
      end
      repeat (3) tick();
      for (int d = 0; d < 2; d++) begin
         check("reset_pix_valid", 32'(pv[d]), 32'd0);
         check("reset_frame_result", fr[d], 32'd0);
         check("reset_busy", 32'(bsy[d]), 32'd0);
         check("reset_errors", {30'd0, derr[d], terr[d]}, 32'd0);
      end
      rst = 1'b0;
      tick();

      for (int v = 0; v < 7; v++) begin
         if (vecs[v].sync) begin
            fs[vecs[v].d] = 1'b1;
            tick();
            fs[vecs[v].d] = 1'b0;
            check("sync_clears_errors", {30'd0, derr[vecs[v].d], terr[vecs[v].d]}, 32'd0);
         end
         cap_n[vecs[v].d] = 0;
         send_frame(vecs[v].d, vecs[v].mode, vecs[v].val, 1'b0, t_last);
         capture(vecs[v].d, (vecs[v].d == 0) ? 0 : 2, vecs[v].mode, vecs[v].val, vecs[v].drop, t_last, s_last);
         resolve(vecs[v].d, s_last, vecs[v].delay, vecs[v].res, vecs[v].exp_tmo, vecs[v].exp_drop, vecs[v].exp_fr);
      end

      // Partial frame, stray result in LOAD, then resync coinciding with the first real byte
      tick();
      for (int i = 0; i < 100; i++) begin
         iv[0] = 1'b1;
         id[0] = 8'hAA;
         tick();
      end
      iv[0]  = 1'b0;
      crv[0] = 1'b1;
      cr[0]  = 32'hBAD0_BAD0;
      tick();
      crv[0] = 1'b0;
      tick();
      check("ignored_result_strobe", 32'(frv[0]), 32'd0);
      check("ignored_result_value", fr[0], 32'd3);
      cap_n[0] = 0;
      send_frame(0, 1, 8'h55, 1'b1, t_last);
      capture(0, 0, 1, 8'h55, 1'b0, t_last, s_last);
      resolve(0, s_last, 4, 32'h0000_55AA, 1'b0, 1'b0, 32'h0000_55AA);

      // Reset while streaming, then a clean frame
      cap_n[0] = 0;
      send_frame(0, 0, 8'h00, 1'b0, t_last);
      guard = 0;
      while (cap_n[0] < 300 && guard < 400) begin
         tick();
         guard++;
      end
      check("reached_pixel_300", 32'(cap_n[0]), 32'd300);
      rst = 1'b1;
      #1;
      check("midreset_pix_valid", 32'(pv[0]), 32'd0);
      check("midreset_pix_data", 32'(pd[0]), 32'd0);
      check("midreset_frame_result", fr[0], 32'd0);
      check("midreset_busy", 32'(bsy[0]), 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      n_before = cap_n[0];
      repeat (30) tick();
      check("no_pixel_after_reset", 32'(cap_n[0] - n_before), 32'd0);
      cap_n[0] = 0;
      send_frame(0, 0, 8'h00, 1'b0, t_last);
      capture(0, 0, 0, 8'h00, 1'b0, t_last, s_last);
      resolve(0, s_last, 2, 32'h0000_1234, 1'b0, 1'b0, 32'h0000_1234);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mnist_frame_feeder.md
# mnist_frame_feeder

Upstream feeder for the MNIST inference core. It accepts a byte stream from the host link (UART receiver), buffers one complete 28x28 frame, and replays it to the core's pixel input at a controlled rate. It then waits for the core's classification result, latches it, and reports it with a one-cycle strobe. It sits between the UART byte receiver and `mnist_network_core`, driving that core's `valid_in`/`pixel_in` and consuming its `result`/`result_valid`.

## Interface
- `NUM_PIXELS`, 784: bytes per frame. Also the buffer depth.
- `PIXEL_GAP`, 0: idle cycles inserted between consecutive streamed pixels.
- `TIMEOUT`, 65535: maximum cycles to wait for the core result after the last pixel.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input byte strobe.
- `in_data`  in  8  input pixel byte.
- `frame_sync`  in  1  pulse: discard any partial frame and clear the sticky errors.
- `pix_valid`  out  1  pixel strobe to the core (`valid_in`).
- `pix_data`  out  8  pixel to the core (`pixel_in`).
- `core_result`  in  32  core `result`.
- `core_result_valid`  in  1  core `result_valid`.
- `frame_result`  out  32  latched result of the last completed frame.
- `frame_result_valid`  out  1  one-cycle strobe when `frame_result` updates.
- `busy`  out  1  high in STREAM and WAIT.
- `drop_err`  out  1  sticky: a byte arrived outside LOAD.
- `timeout_err`  out  1  sticky: the core result did not arrive within `TIMEOUT` cycles.

## Operation
- Buffer: `NUM_PIXELS` x 8 RAM with synchronous read. Write pointer `wptr` and read pointer `rptr`, each 10 bits.
- States: LOAD, STREAM, WAIT.
- **LOAD**
  - Each `in_valid` writes `in_data` to `mem[wptr]` and increments `wptr`.
  - The write at `wptr == NUM_PIXELS-1` sets `wptr` to 0 and moves to STREAM.
- **STREAM**
  - Reads `mem[0..NUM_PIXELS-1]` in order.
  - Asserts `pix_valid` for one cycle per pixel, with `PIXEL_GAP` idle cycles between pixels.
  - After the last pixel strobe, moves to WAIT and clears the timeout counter.
- **WAIT**
  - The first `core_result_valid` loads `frame_result` from `core_result`, pulses `frame_result_valid` on the next cycle, and returns to LOAD.
  - If `TIMEOUT` cycles pass without a result: sets `timeout_err` and returns to LOAD; `frame_result` is unchanged.
- `core_result_valid` outside WAIT is ignored.
- `in_valid` in STREAM or WAIT: the byte is dropped and `drop_err` is set. The buffer and the stream are unaffected.
- `frame_sync`
  - In LOAD: `wptr` goes to 0. If `in_valid` is asserted in the same cycle, that byte is written to address 0 and `wptr` becomes 1.
  - In any state: clears `drop_err` and `timeout_err`.
  - In STREAM or WAIT: no effect beyond clearing the errors. An active frame is never aborted.
- If an error set and `frame_sync` coincide in the same cycle, set wins.
- `pix_data` holds its last value when `pix_valid` is low.

## Timing
- Reset: all outputs are 0, state is LOAD, and `wptr`, `rptr` and the timeout counter are 0. This applies mid-frame as well: the partial frame is lost and `pix_valid` drops on reset assertion.
- Stream start: the last byte is accepted in cycle T. The read of address 0 is issued in T+1, and the first `pix_valid` is in T+2.
- Pixel k has `pix_valid` in cycle T+2+k*(PIXEL_GAP+1).
- `PIXEL_GAP=0` gives `NUM_PIXELS` contiguous `pix_valid` cycles.
- WAIT is entered the cycle after the last pixel strobe. `busy` is high from T+1 through the cycle WAIT exits.
- `core_result_valid` in WAIT at cycle R: `frame_result` is valid and `frame_result_valid` is high in R+1. In R+1 the state is LOAD and `in_valid` is accepted.
- Timeout: with W the first WAIT cycle, `timeout_err` rises and the state returns to LOAD at W+TIMEOUT.
- A `core_result_valid` in the same cycle as the timeout expiry counts as a valid result; no error is raised.
- Back-to-back frames: the next frame's bytes may start the cycle after `frame_result_valid`.
- Pointer arithmetic is modulo `NUM_PIXELS` by explicit compare, not modulo power of two.

## Test plan
- Ramp frame, `PIXEL_GAP=0`: send 784 bytes with `in_data = i mod 256`. Required: 784 contiguous `pix_valid` cycles starting at T+2 with data 0..255,0..255,0..255,0..15. The core model returns 0x00000007 → `frame_result = 7`, a single strobe, and `busy` drops.
- `PIXEL_GAP=2`: same frame. Required: `pix_valid` exactly every 3rd cycle, 784 strobes, data in order.
- Resync: send 100 bytes of 0xAA, pulse `frame_sync`, then send 784 bytes of 0x55. Required: all streamed pixels are 0x55, with the first at T+2 after the 784th 0x55 byte.
- Drop: 5 `in_valid` bytes of 0xFF during STREAM. Required: `drop_err = 1`, the stream is unchanged, and `drop_err` clears on the next `frame_sync`.
- Timeout: `TIMEOUT=16` with no core result. Required: `timeout_err` rises at W+16, the state returns to LOAD, and `frame_result` keeps its previous value. A second frame then completes normally.
- Reset at pixel 300: required all outputs 0 immediately and no further `pix_valid`. A fresh 784-byte frame then streams correctly.
